// File: rtl/spi_reg_bank.sv
// ---------------------------------------------------------------------------
// spi_reg_bank
//
// SPI Mode 0 write-register slave feeding the PWM peripheral. Serial frames
// arriving on the SPI pins are oversampled in the clk domain; nothing is
// clocked by sclk. A 16-bit frame {rw, addr[6:0], data[7:0]} (MSB first)
// with rw=1 and addr <= MAX_ADDR writes data into one of five registers.
//
// Optional feature: define SPI_READBACK_EN to make rw=0 frames reads that
// return the addressed register on cipo. Without it cipo is tied to 0.
//
// Ports:
//   clk              system clock
//   rst_n            synchronous active-low reset
//   sclk, copi, ncs  SPI pins, asynchronous to clk
//   cipo             SPI data out (readback only, else 0)
//   en_reg_out_7_0   register 0x00
//   en_reg_out_15_8  register 0x01
//   en_reg_pwm_7_0   register 0x02
//   en_reg_pwm_15_8  register 0x03
//   pwm_duty_cycle   register 0x04
// ---------------------------------------------------------------------------
module spi_reg_bank #(
   parameter int MAX_ADDR    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic       cipo,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle
);

   localparam int NUM_REGS = 5;

   typedef enum logic [1:0] {IDLE, ARMED, SHIFT, COMMIT} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
   logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
   logic                   sclk_hist_q, sclk_hist_d;
   logic                   ncs_hist_q, ncs_hist_d;
   logic [4:0]             cnt_q, cnt_d;
   logic [15:0]            shreg_q, shreg_d;
   logic [7:0]             regs_q [NUM_REGS];
   logic [7:0]             regs_d [NUM_REGS];

`ifdef SPI_READBACK_EN
   logic [7:0]             tx_q, tx_d;
   logic                   rd_q, rd_d;
   logic                   sclk_fall;
`endif

   // Last synchroniser stage is the only view of the pins the logic uses.
   logic sclk_s, copi_s, ncs_s;
   logic sclk_rise, ncs_rise, ncs_fall;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign copi_s    = copi_sync_q[SYNC_STAGES-1];
   assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_hist_q;
   assign ncs_rise  = ncs_s & ~ncs_hist_q;
   assign ncs_fall  = ~ncs_s & ncs_hist_q;
`ifdef SPI_READBACK_EN
   assign sclk_fall = ~sclk_s & sclk_hist_q;
`endif

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_hist_d = sclk_s;
      ncs_hist_d  = ncs_s;
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      regs_d      = regs_q;
`ifdef SPI_READBACK_EN
      tx_d        = tx_q;
      rd_d        = rd_q;
`endif

      case (state_q)
         // Wait for a deselected bus so a frame caught mid-flight at reset
         // release is never mistaken for a new one.
         IDLE: begin
            if (ncs_s) state_d = ARMED;
         end
         ARMED: begin
            if (ncs_fall) begin
               state_d = SHIFT;
               cnt_d   = '0;
               shreg_d = '0;
            end
         end
         SHIFT: begin
            if (ncs_rise) begin
               // An sclk edge landing in the same cycle is dropped here.
               state_d = COMMIT;
`ifdef SPI_READBACK_EN
               rd_d    = 1'b0;
`endif
            end else if (sclk_rise && !ncs_s) begin
               shreg_d = {shreg_q[14:0], copi_s};
               if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
`ifdef SPI_READBACK_EN
               // Header complete after the 8th bit: fetch the read value.
               if (cnt_q == 5'd7 && !shreg_d[7] && int'(shreg_d[6:0]) <= MAX_ADDR) begin
                  rd_d = 1'b1;
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (shreg_d[6:0] == 7'(i)) tx_d = regs_q[i];
                  end
               end
`endif
            end
`ifdef SPI_READBACK_EN
            // Hold the MSB for the first data bit, then advance on each
            // falling edge so the master samples bit n on rising edge n.
            else if (sclk_fall && rd_q && cnt_q >= 5'd9) begin
               tx_d = {tx_q[6:0], 1'b0};
            end
`endif
         end
         COMMIT: begin
            state_d = ARMED;
            if (cnt_q == 5'd16 && shreg_q[15] && int'(shreg_q[14:8]) <= MAX_ADDR) begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (shreg_q[14:8] == 7'(i)) regs_d[i] = shreg_q[7:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the values from before this edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sclk_sync_q <= '0;
         copi_sync_q <= '0;
         ncs_sync_q  <= '0;
         sclk_hist_q <= 1'b0;
         ncs_hist_q  <= 1'b0;
         cnt_q       <= '0;
         shreg_q     <= '0;
         // NOTE: the register array is reset because it drives the PWM
         // control outputs directly and they must come up as 0x00.
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef SPI_READBACK_EN
         tx_q        <= '0;
         rd_q        <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= sclk_sync_d;
         copi_sync_q <= copi_sync_d;
         ncs_sync_q  <= ncs_sync_d;
         sclk_hist_q <= sclk_hist_d;
         ncs_hist_q  <= ncs_hist_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
`ifdef SPI_READBACK_EN
         tx_q        <= tx_d;
         rd_q        <= rd_d;
`endif
      end
   end

`ifdef SPI_READBACK_EN
   assign cipo = rd_q & tx_q[7];
`else
   assign cipo = 1'b0;
`endif

   assign en_reg_out_7_0  = regs_q[0];
   assign en_reg_out_15_8 = regs_q[1];
   assign en_reg_pwm_7_0  = regs_q[2];
   assign en_reg_pwm_15_8 = regs_q[3];
   assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_spi_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_bank
//
// Drives SPI frames at a slow SCLK (HALF clk periods per phase) and keeps a
// frame-level model of the five registers. A compare process checks every
// output against the model on each falling clk edge; the model applies a
// frame three clk edges after the edge that first samples ncs high.
// ---------------------------------------------------------------------------
module tb_spi_reg_bank;

   localparam int HALF = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       copi = 1'b0;
   logic       ncs = 1'b1;
   logic       cipo;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0;
   logic [7:0] en_reg_pwm_15_8, pwm_duty_cycle;

   logic [7:0] exp_reg [0:4];
   logic [7:0] rx_byte;
   int         n_checks = 0;
   int         n_errors = 0;
   bit         cmp_on = 1'b0;

   always #5 clk = ~clk;

   spi_reg_bank dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sclk            (sclk),
      .copi            (copi),
      .ncs             (ncs),
      .cipo            (cipo),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame rule: exactly 16 bits, write bit set, address inside the bank.
   function automatic void model_frame(input logic [31:0] word, input int nbits);
      if (nbits == 16 && word[15] && int'(word[14:8]) <= 4)
         exp_reg[int'(word[14:8])] = word[7:0];
   endfunction

   always @(negedge clk) begin
      if (cmp_on) begin
         check("reg0", en_reg_out_7_0,  exp_reg[0]);
         check("reg1", en_reg_out_15_8, exp_reg[1]);
         check("reg2", en_reg_pwm_7_0,  exp_reg[2]);
         check("reg3", en_reg_pwm_15_8, exp_reg[3]);
         check("reg4", pwm_duty_cycle,  exp_reg[4]);
`ifndef SPI_READBACK_EN
         check("cipo", {7'b0, cipo}, 8'h00);
`endif
      end
   end

   task automatic cs_low();
      @(negedge clk) ncs = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   // Send bits [first, last) of an nbits word, MSB first; capture cipo just
   // before each data-phase rising edge.
   task automatic send_bits(input logic [31:0] word, input int nbits, input int first, input int last);
      for (int i = first; i < last; i++) begin
         copi = word[nbits-1-i];
         repeat (HALF) @(negedge clk);
         if (i >= 8 && i < 16) rx_byte[15-i] = cipo;
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic cs_high_commit(input logic [31:0] word, input int nbits, input bit apply);
      copi = 1'b0;
      repeat (HALF) @(negedge clk);
      ncs = 1'b1;
      @(posedge clk);               // edge k
      repeat (3) @(posedge clk);    // edge k+3
      #1;
      if (apply) model_frame(word, nbits);
      repeat (4) @(negedge clk);
   endtask

   task automatic frame(input logic [31:0] word, input int nbits);
      cs_low();
      send_bits(word, nbits, 0, nbits);
      cs_high_commit(word, nbits, 1'b1);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
      repeat (cycles) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
      rx_byte = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_reg0", en_reg_out_7_0, 8'h00);
      check("rst_reg1", en_reg_out_15_8, 8'h00);
      check("rst_reg2", en_reg_pwm_7_0, 8'h00);
      check("rst_reg3", en_reg_pwm_15_8, 8'h00);
      check("rst_reg4", pwm_duty_cycle, 8'h00);
      check("rst_cipo", {7'b0, cipo}, 8'h00);
      cmp_on = 1'b1;
      rst_n  = 1'b1;
      repeat (10) @(negedge clk);

      // Basic writes
      frame(32'h80F0, 16);
      check("lit_reg0_F0", en_reg_out_7_0, 8'hF0);
      check("lit_reg4_idle", pwm_duty_cycle, 8'h00);
      frame(32'h8480, 16);
      check("lit_reg4_80", pwm_duty_cycle, 8'h80);
      frame(32'h835A, 16);
      check("lit_reg3_5A", en_reg_pwm_15_8, 8'h5A);
      check("lit_reg4_kept", pwm_duty_cycle, 8'h80);

      // Out-of-range address and read-type frame are discarded
      frame(32'h85FF, 16);
      frame(32'h7FFF, 16);
      check("lit_reg0_kept", en_reg_out_7_0, 8'hF0);
      check("lit_reg3_kept", en_reg_pwm_15_8, 8'h5A);

      // Short and long frames carrying write 0x82 0x33
      frame(32'h8233 >> 1, 15);
      frame(32'h8233 << 1, 17);
      check("lit_reg2_len", en_reg_pwm_7_0, 8'h00);

      // Extra sclk edge in the same cycle as the ncs rise is ignored
      cs_low();
      send_bits(32'h8211, 16, 0, 16);
      copi = 1'b0;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      ncs  = 1'b1;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1 model_frame(32'h8211, 16);
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      check("lit_reg2_coinc", en_reg_pwm_7_0, 8'h11);

      // Reset in the middle of a frame, released with ncs still low
      cs_low();
      send_bits(32'h81AA, 16, 0, 10);
      do_reset(3);
      send_bits(32'h81AA, 16, 10, 16);
      cs_high_commit(32'h81AA, 16, 1'b0);
      check("lit_reg1_lost", en_reg_out_15_8, 8'h00);
      check("lit_reg0_cleared", en_reg_out_7_0, 8'h00);
      frame(32'h81AA, 16);
      check("lit_reg1_AA", en_reg_out_15_8, 8'hAA);

      // Readback frame
      frame(32'h84C3, 16);
      rx_byte = 8'h00;
      cs_low();
      send_bits(32'h0400, 16, 0, 16);
      cs_high_commit(32'h0400, 16, 1'b1);
`ifdef SPI_READBACK_EN
      check("read_cipo", rx_byte, 8'hC3);
`else
      check("read_cipo_off", rx_byte, 8'h00);
`endif
      check("lit_reg4_C3", pwm_duty_cycle, 8'hC3);

      cmp_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- SPI Mode 0 write-register slave that sits directly upstream of the PWM peripheral.
- Receives serial frames on the ui_in SPI pins and drives the five control registers consumed by the PWM block.
- All SPI inputs are oversampled and synchronised into the clk domain; no logic is clocked by SCLK.

Parameters:
- MAX_ADDR, 4, highest valid register address; writes above it are discarded.
- SYNC_STAGES, 2, synchroniser flops on each SPI input; minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- sclk  input  1  SPI clock (ui_in[0]), asynchronous to clk
- copi  input  1  SPI data in (ui_in[1]), asynchronous
- ncs  input  1  SPI chip select, active low (ui_in[2]), asynchronous
- cipo  output  1  SPI data out; meaningful only with SPI_READBACK_EN
- en_reg_out_7_0  output  8  register 0x00
- en_reg_out_15_8  output  8  register 0x01
- en_reg_pwm_7_0  output  8  register 0x02
- en_reg_pwm_15_8  output  8  register 0x03
- pwm_duty_cycle  output  8  register 0x04

Behaviour:
- Reset: synchronous, active-low. While rst_n=0 at a clk edge:
  - all five registers = 0x00; cipo = 0
  - bit counter, shift register and synchroniser flops cleared
  - FSM goes to IDLE
- Synchronisers:
  - sclk, copi and ncs each pass through SYNC_STAGES flops, plus one history flop.
  - Edges are detected from the last synchronised stage and its history flop.
- Input timing requirement: SCLK high and low phases are each ≥ 3 clk periods. Faster SCLK is unsupported.
- Frame format: 16 bits, MSB first.
  - bit15 = R/W (1 = write)
  - bits14:8 = 7-bit address
  - bits7:0 = data
- FSM:
  - IDLE → ARMED when synchronised ncs is high. A frame already in progress at reset release is therefore ignored.
  - ARMED → SHIFT on a synchronised ncs falling edge; bit counter and shift register cleared to 0.
  - SHIFT: on each synchronised sclk rising edge with ncs low, shift in synchronised copi and increment the counter, saturating at 17.
  - SHIFT → COMMIT on a synchronised ncs rising edge.
  - COMMIT (one cycle): write data to register[addr] only if counter == 16, R/W = 1 and addr ≤ MAX_ADDR; otherwise discard. Then → ARMED.
- Latency: with synchroniser depth 2, the first clk edge that samples pin ncs high is edge k. The target register updates at edge k+3, held stably from then on.
- Other registers are never disturbed by any frame.
- Boundaries:
  - <16 or >16 SCLK rising edges → frame discarded.
  - sclk rising edge coincident with ncs rising edge (same clk cycle) → the sclk edge is ignored.
  - Writes to address 0x05–0x7F → discarded, no error.
  - R/W = 0 without the feature → discarded.
  - rst_n low mid-frame → frame lost, registers = 0x00, return to IDLE.

Optional Feature:
- Macro: SPI_READBACK_EN.
- Defined:
  - Frames with R/W = 0 and addr ≤ MAX_ADDR are reads.
  - After the 8th synchronised sclk rising edge, the 8-bit register value is loaded into a TX shift register.
  - cipo presents the MSB of that value and shifts on each subsequent synchronised sclk falling edge.
  - cipo = 0 while ncs is high, and for invalid addresses.
  - Reads never modify registers.
- Undefined: cipo is tied to 0 and no TX logic is present.

Test Plan:
- Reset, then write 0x80 0xF0 (addr 0x00) → en_reg_out_7_0 = 0xF0 at edge k+3; other outputs stay 0x00.
- Write 0x84 0x80 → pwm_duty_cycle = 0x80. Then write 0x83 0x5A → en_reg_pwm_15_8 = 0x5A; pwm_duty_cycle still 0x80.
- Write 0x85 0xFF (addr 5) → no output changes. Write 0x7F 0xFF (addr 0x7F with R/W bit 0) → no output changes.
- 15-bit frame and 17-bit frame, each carrying write 0x82 0x33 → en_reg_pwm_7_0 remains 0x00.
- Assert rst_n = 0 after 10 bits of write 0x81 0xAA, release with ncs still low, finish the frame → en_reg_out_15_8 = 0x00. Next full write 0x81 0xAA → 0xAA.
- With SPI_READBACK_EN: write 0x84 0xC3, then read frame 0x04 0x00 → cipo bits 1100_0011 on bits 7..0. Without the macro: cipo stays 0 and registers are unchanged.
